// File: rtl/rc_hpf_channel_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rc_hpf_sched_pkg
// Purpose  : Shared types, widths and the output clamp/wrap helper for the
//            time-multiplexed RC high-pass filter scheduler.
// Macro    : RC_HPF_SCHED_SATURATE_EN - when defined sat16 clamps, otherwise
//            it keeps the low 16 bits (two's-complement wrap).
// Revision : 1.0 - initial release
// ============================================================================
package rc_hpf_sched_pkg;

  localparam int SAMPLE_W = 16;
  localparam int COEF_W   = 16;
  localparam int SUM_W    = 18;
  localparam int PROD_W   = 35;
  localparam int SHIFT    = 16;
  localparam int RES_W    = PROD_W - SHIFT;  // width of prod >>> 16

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_MUL   = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [RES_W-1:0] r);
`ifdef RC_HPF_SCHED_SATURATE_EN
    if (r > 19'sd32767)
      sat16 = 16'sh7FFF;
    else if (r < -19'sd32768)
      sat16 = 16'sh8000;
    else
      sat16 = SAMPLE_W'(r);
`else
    sat16 = SAMPLE_W'(r);
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/rc_hpf_channel_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : rc_hpf_channel_scheduler_if
// Purpose  : Bundles the sample strobe, sample buses, coefficient write port
//            and status flags of the channel scheduler.
// Ports    : master drives audio_clk_en, in_samples, coef_wr/addr/data and
//            receives out_samples, busy, frame_done, overrun; slave mirrors.
// Revision : 1.0 - initial release
// ============================================================================
interface rc_hpf_channel_scheduler_if #(
  parameter int NUM_CHANNELS = 4
);
  localparam int AW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic                       audio_clk_en;
  logic [16*NUM_CHANNELS-1:0] in_samples;
  logic                       coef_wr;
  logic [AW-1:0]              coef_addr;
  logic [15:0]                coef_data;
  logic [16*NUM_CHANNELS-1:0] out_samples;
  logic                       busy;
  logic                       frame_done;
  logic                       overrun;

  modport master (
    output audio_clk_en, in_samples, coef_wr, coef_addr, coef_data,
    input  out_samples, busy, frame_done, overrun
  );

  modport slave (
    input  audio_clk_en, in_samples, coef_wr, coef_addr, coef_data,
    output out_samples, busy, frame_done, overrun
  );
endinterface
`default_nettype wire

// File: rtl/rc_hpf_channel_scheduler_datapath.sv
`default_nettype none
// ============================================================================
// Module   : rc_hpf_datapath
// Purpose  : Shared filter arithmetic y = a*(y_prev + x - x_prev), split into
//            a registered sum stage (LOAD) and a registered product stage
//            (MUL); the shifted/saturated result is combinational for WRITE.
// Ports    : clk, reset; load_en_i, mul_en_i stage enables; x_i, x_prev_i,
//            y_prev_i, coef_i operands; y_o filtered result.
// Revision : 1.0 - initial release
// ============================================================================
module rc_hpf_datapath
  import rc_hpf_sched_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_en_i,
  input  logic                       mul_en_i,
  input  logic signed [SAMPLE_W-1:0] x_i,
  input  logic signed [SAMPLE_W-1:0] x_prev_i,
  input  logic signed [SAMPLE_W-1:0] y_prev_i,
  input  logic        [COEF_W-1:0]   coef_i,
  output logic signed [SAMPLE_W-1:0] y_o
);

  logic signed [SUM_W-1:0]  sum_q, sum_d;
  logic        [COEF_W-1:0] coef_q;
  logic signed [PROD_W-1:0] prod_q, prod_d;

  always_comb begin
    sum_d  = {{2{y_prev_i[SAMPLE_W-1]}}, y_prev_i} + {{2{x_i[SAMPLE_W-1]}}, x_i}
           - {{2{x_prev_i[SAMPLE_W-1]}}, x_prev_i};
    // Coefficient is unsigned; a zero MSB makes it a positive 17-bit signed operand.
    prod_d = sum_q * $signed({1'b0, coef_q});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q  <= '0;
      coef_q <= '0;
      prod_q <= '0;
    end else begin
      if (load_en_i) begin
        sum_q  <= sum_d;
        coef_q <= coef_i;
      end
      if (mul_en_i)
        prod_q <= prod_d;
    end
  end

  // Top slice of the product is prod >>> 16 with its sign bits intact.
  assign y_o = sat16(prod_q[PROD_W-1:SHIFT]);

endmodule
`default_nettype wire

// File: rtl/rc_hpf_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rc_hpf_channel_scheduler
// Purpose  : Sequences NUM_CHANNELS voices through one RC high-pass datapath
//            per audio strobe (3 cycles per channel), holding per-channel
//            history and a runtime-writable coefficient bank.
// Ports    : clk, reset (async, active-high); bus (slave modport) carries
//            strobe, packed inputs, coef write port, packed outputs, busy,
//            frame_done and sticky overrun.
// Macro    : RC_HPF_SCHED_SATURATE_EN selects clamping instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module rc_hpf_channel_scheduler
  import rc_hpf_sched_pkg::*;
#(
  parameter int          NUM_CHANNELS = 4,
  parameter int          CLOCK_RATE   = 1000000,
  parameter int          SAMPLE_RATE  = 48000,
  parameter logic [15:0] DEFAULT_COEF = 16'hF000
) (
  input  logic                       clk,
  input  logic                       reset,
  rc_hpf_channel_scheduler_if.slave  bus
);

  localparam int AW   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int LAST = NUM_CHANNELS - 1;

  if ((NUM_CHANNELS < 1) || (NUM_CHANNELS > 16)
      || (3 * NUM_CHANNELS >= CLOCK_RATE / SAMPLE_RATE)) begin : g_param_check
    $error("rc_hpf_channel_scheduler: channel count does not fit the sample period");
  end

  state_e                     state_q, state_d;
  logic [AW-1:0]              ch_q, ch_d;
  logic signed [SAMPLE_W-1:0] x_snap_q [NUM_CHANNELS];
  logic signed [SAMPLE_W-1:0] x_prev_q [NUM_CHANNELS];
  logic signed [SAMPLE_W-1:0] y_prev_q [NUM_CHANNELS];
  logic        [COEF_W-1:0]   coef_q   [NUM_CHANNELS];
  logic                       frame_done_q, overrun_q;
  logic                       load_en, mul_en, wr_en, last_ch, accept;
  logic signed [SAMPLE_W-1:0] y_new;

  assign last_ch = (ch_q == AW'(LAST));
  // A strobe in the final WRITE cycle starts the next frame back-to-back.
  assign accept  = bus.audio_clk_en
                 && ((state_q == ST_IDLE) || ((state_q == ST_WRITE) && last_ch));

  // ---- FSM: state register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_LOAD;
          ch_d    = '0;
        end
      end
      ST_LOAD:  state_d = ST_MUL;
      ST_MUL:   state_d = ST_WRITE;
      ST_WRITE: begin
        if (!last_ch) begin
          state_d = ST_LOAD;
          ch_d    = ch_q + 1'b1;
        end else if (accept) begin
          state_d = ST_LOAD;
          ch_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    load_en  = (state_q == ST_LOAD);
    mul_en   = (state_q == ST_MUL);
    wr_en    = (state_q == ST_WRITE);
    bus.busy = (state_q != ST_IDLE);
  end

  rc_hpf_datapath u_datapath (
    .clk       (clk),
    .reset     (reset),
    .load_en_i (load_en),
    .mul_en_i  (mul_en),
    .x_i       (x_snap_q[ch_q]),
    .x_prev_i  (x_prev_q[ch_q]),
    .y_prev_i  (y_prev_q[ch_q]),
    .coef_i    (coef_q[ch_q]),
    .y_o       (y_new)
  );

  // Snapshot, history and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        x_snap_q[i] <= '0;
        x_prev_q[i] <= '0;
        y_prev_q[i] <= '0;
      end
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < NUM_CHANNELS; i++)
          x_snap_q[i] <= bus.in_samples[i*SAMPLE_W +: SAMPLE_W];
      end
      if (wr_en) begin
        y_prev_q[ch_q] <= y_new;
        x_prev_q[ch_q] <= x_snap_q[ch_q];
      end
      frame_done_q <= wr_en && last_ch;
      if (bus.audio_clk_en && !accept)
        overrun_q <= 1'b1;
    end
  end

  // Coefficient bank: writes land on any edge; LOAD has already latched its copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++)
        coef_q[i] <= DEFAULT_COEF;
    end else if (bus.coef_wr && (32'(bus.coef_addr) < NUM_CHANNELS)) begin
      coef_q[bus.coef_addr] <= bus.coef_data;
    end
  end

  // The stored y history doubles as the registered output.
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_out
    assign bus.out_samples[i*SAMPLE_W +: SAMPLE_W] = y_prev_q[i];
  end

  assign bus.frame_done = frame_done_q;
  assign bus.overrun    = overrun_q;

endmodule
`default_nettype wire

// File: doc/rc_hpf_channel_scheduler.md
# rc_hpf_channel_scheduler

Time-multiplexes one RC high-pass filter datapath (single subtract/add, one 18×17 multiplier, saturation) across NUM_CHANNELS audio voices of a discrete-sound board. On every audio_clk_en strobe it snapshots all channel inputs and sequences them through the shared datapath. It keeps per-channel filter state and a runtime-writable coefficient per channel. It sits between the 555/VCO sound generators and the mixer.

## Interface
- NUM_CHANNELS, 4: number of filtered voices (1..16)
- CLOCK_RATE, 1000000: system clock in Hz
- SAMPLE_RATE, 48000: audio_clk_en rate; elaboration error if 3*NUM_CHANNELS >= CLOCK_RATE/SAMPLE_RATE
- DEFAULT_COEF, 16'hF000: reset value of every coefficient, unsigned Q0.16
- clk  in  1  system clock, single clock domain
- reset  in  1  asynchronous, active-high
- audio_clk_en  in  1  one-cycle sample strobe; starts a frame
- in_samples  in  16*NUM_CHANNELS  packed signed inputs, channel 0 in bits [15:0]
- coef_wr  in  1  coefficient write strobe
- coef_addr  in  $clog2(NUM_CHANNELS) (min 1)  channel to write
- coef_data  in  16  coefficient a = RC/(RC+1/SAMPLE_RATE), Q0.16
- out_samples  out  16*NUM_CHANNELS  packed signed filtered outputs, registered
- busy  out  1  high while a frame is in progress
- frame_done  out  1  one-cycle pulse after the last channel is written
- overrun  out  1  sticky; strobe arrived while busy

## Operation
- Per channel: y[n] = a * (y[n-1] + x[n] - x[n-1]).
- State per channel: x_prev, y_prev (16-bit signed), coef (16-bit). All reset to 0 except coef = DEFAULT_COEF.
- FSM states: IDLE, LOAD, MUL, WRITE; channel counter ch.
- IDLE: audio_clk_en=1 -> snapshot all in_samples, ch=0, go LOAD.
- LOAD: sum = y_prev[ch] + x[ch] - x_prev[ch], 18-bit signed; latch coef[ch]; go MUL.
- MUL: prod = sum * {1'b0,coef}, 35-bit signed; go WRITE.
- WRITE: r = prod >>> 16 (arithmetic). Store y_prev[ch]=out[ch]=sat16(r) and x_prev[ch]=x[ch]. If ch==NUM_CHANNELS-1, go IDLE and pulse frame_done; else ch+1, go LOAD.
- audio_clk_en while not IDLE: ignored, overrun<=1 (cleared only by reset).
- Coefficient write: applied on the clock edge regardless of FSM state. A write on the edge that leaves LOAD for that channel is not seen this frame; it takes effect on the next frame.
- Reset mid-frame: FSM to IDLE. All state, outputs, busy, frame_done and overrun go to 0, coefs to DEFAULT_COEF. The next frame starts from zero history.

## Timing
- Strobe sampled at edge 0. Channel i computes in cycles 3i..3i+2; out ch i updates at edge 3i+3.
- busy = (state != IDLE): high for exactly 3*NUM_CHANNELS cycles.
- frame_done high for the single cycle after edge 3*NUM_CHANNELS.
- Earliest accepted next strobe: edge 3*NUM_CHANNELS. A strobe on any edge 1..3*NUM_CHANNELS-1 is an overrun.
- Inputs are sampled only at the strobe edge; later changes do not affect the frame.

## Configuration
- RC_HPF_SCHED_SATURATE_EN defined: sat16 clamps r to [-32768, 32767].
- Not defined: sat16 takes r[15:0] (two's-complement wrap). Saves the comparators.

## Structure
- Package rc_hpf_sched_pkg holds:
  - state enum
  - SAMPLE_W=16, COEF_W=16, SUM_W=18, PROD_W=35
  - function sat16 (honouring the macro)
- Sub-module rc_hpf_datapath holds the registered sum -> multiply -> shift/saturate path. It takes x, x_prev, y_prev and coef and returns y. The scheduler owns the FSM, snapshot, state RAM/registers and coef bank.

## Test plan
- Reset, then release -> out_samples all 0, busy 0, frame_done 0, overrun 0. A strobe with zero inputs leaves outputs 0.
- N=4, coef[0]=0x8000, ch0 input held at 16384 -> ch0 output 8192, 4096, 2048 on frames 1-3. Channels 1-3 stay 0.
- Strobe at edge 0 (N=4) -> busy for cycles 0-11, out ch0 changes at edge 3, ch3 at edge 12, frame_done only after edge 12.
- coef[1]=0xFFFF, ch1 input 32767 then -32768 -> frame1 32766. Frame2 gives -32768 with RC_HPF_SCHED_SATURATE_EN, 32767 without.
- Second strobe at edge 5 -> ignored, overrun=1 and stays 1, one frame_done. A strobe at edge 12 is accepted without overrun.
- Reset asserted at edge 7 mid-frame -> all outputs 0 immediately. The next frame with ch0=16384, coef 0x8000 yields 8192.
